cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameters: none; burst length fixed at 4 beats x 64 bits = one 256-bit line.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_read  input  1  I-cache line-fill request.
REQ-005 i_address  input  32  I-cache line address.
REQ-006 i_rdata  output  256  I-cache fill line.
REQ-007 i_resp  output  1  I-cache fill complete.
REQ-008 d_read  input  1  D-cache line-fill request.
REQ-009 d_write  input  1  D-cache writeback request.
REQ-010 d_address  input  32  D-cache line address.
REQ-011 d_wdata  input  256  D-cache writeback line.
REQ-012 d_rdata  output  256  D-cache fill line.
REQ-013 d_resp  output  1  D-cache request complete.
REQ-014 pmem_read  output  1  burst read to physical memory.
REQ-015 pmem_write  output  1  burst write to physical memory.
REQ-016 pmem_address  output  32  burst base address.
REQ-017 pmem_wdata  output  64  write beat data.
REQ-018 pmem_rdata  input  64  read beat data.
REQ-019 pmem_resp  input  1  one beat accepted/returned this cycle.

Function
REQ-020 FSM states: IDLE, I_RD, D_RD, D_WR, DONE; Moore outputs decoded from state register.
REQ-021 IDLE: no request -> stay; exactly one requester -> grant it; both -> grant the requester not granted last (1-bit last_grant, reset to I, so D wins the first tie).
REQ-022 D-side: d_write and d_read both high -> D_WR; d_read is ignored for that grant.
REQ-023 pmem_read high exactly in I_RD/D_RD; pmem_write high exactly in D_WR; never both.
REQ-024 pmem_address = {granted address[31:5], 5'b0}, latched at grant, constant for the whole burst.
REQ-025 2-bit beat counter cleared at grant, incremented on each pmem_resp; pmem_resp with counter 3 -> DONE.
REQ-026 Read beat k written to line buffer bits [64k+63:64k]; beats may be non-consecutive (gaps with pmem_resp low hold state).
REQ-027 Write: pmem_wdata = d_wdata[64k+63:64k] for current counter k; d_wdata latched at grant.
REQ-028 DONE: assert i_resp or d_resp (granted side only) for exactly one cycle, then IDLE; i_rdata/d_rdata hold the assembled line from DONE until the next grant.
REQ-029 Requester deasserts its request the cycle after its resp; IDLE re-arbitrates on the following cycle (minimum one idle cycle between bursts).
REQ-030 Requests changing mid-burst are ignored until IDLE; pmem_resp in IDLE/DONE is ignored.
REQ-031 Latency: grant 1 cycle after request seen in IDLE; resp 1 cycle after 4th pmem_resp.

Reset
REQ-032 rst high -> state IDLE, counter 0, last_grant I, line buffer 0; all outputs 0 on the next cycle.
REQ-033 Reset mid-burst abandons the burst; no resp is issued for it.

Structure
REQ-034 State enum and constants BEATS=4, LINE_W=256 live in shared package rv32i_types.
REQ-035 One sub-module, line_adapter: 256<->64 beat serializer/deserializer with counter; FSM and arbitration stay in cache_arbiter.

Verification
REQ-036 I-read alone, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address 0x0000_1220, i_rdata = {0x44..,0x33..,0x22..,0x11..}, one-cycle i_resp.
REQ-037 D-write addr 0x8000_0040, d_wdata beat k = k+1 -> pmem_wdata 1,2,3,4 in order, pmem_write held 4 resps, one-cycle d_resp.
REQ-038 i_read and d_read same cycle after reset -> D served first, then I; repeated tie -> alternates.
REQ-039 Beats with 3-cycle gaps between pmem_resp -> state/counter hold, correct line assembled.
REQ-040 rst asserted after 2nd beat -> next cycle pmem_read=0, no resp, next request completes normally.
REQ-041 d_read and d_write both high -> write burst only, pmem_read never high.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and line geometry for the cache-to-memory arbiter.
// A 256-bit cache line moves as four 64-bit beats.
package rv32i_types;

    localparam int BEATS  = 4;
    localparam int LINE_W = 256;
    localparam int BEAT_W = LINE_W / BEATS;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/line_adapter.sv
// Converts between one 256-bit line buffer and 64-bit memory beats.
// The beat counter selects both the write beat and the read beat slot.
module line_adapter
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_vld,
    input  logic              beat_capture,
    input  logic [BEAT_W-1:0] rdata_beat,
    output logic [BEAT_W-1:0] wdata_beat,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    logic [1:0]        cnt_q;
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            if (load) begin
                line_q <= load_line;
            end
        end else if (beat_vld) begin
            cnt_q <= cnt_q + 2'd1;
            if (beat_capture) begin
                line_q[{cnt_q, 6'd0} +: BEAT_W] <= rdata_beat;
            end
        end
    end

    assign wdata_beat = line_q[{cnt_q, 6'd0} +: BEAT_W];
    assign line       = line_q;
    assign last_beat  = (cnt_q == 2'(BEATS - 1));

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one burst
// memory port; ties alternate between the two caches.
module cache_arbiter
    import rv32i_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_read,
    input  logic [31:0]        i_address,
    output logic [LINE_W-1:0]  i_rdata,
    output logic               i_resp,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [31:0]        d_address,
    input  logic [LINE_W-1:0]  d_wdata,
    output logic [LINE_W-1:0]  d_rdata,
    output logic               d_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    output logic [BEAT_W-1:0]  pmem_wdata,
    input  logic [BEAT_W-1:0]  pmem_rdata,
    input  logic               pmem_resp
);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q;
    logic [31:0]       addr_q;
    logic              d_wins;
    logic              grant;
    logic              grant_wr;
    logic              in_burst;
    logic              beat_vld;
    logic              last_beat;
    logic [LINE_W-1:0] line;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{i_address[4:0], d_address[4:0]};

    always_comb begin
        state_d = state_q;
        d_wins  = (d_read || d_write) && (!i_read || last_grant_q == GRANT_I);
        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d = d_write ? D_WR : D_RD;
                end else if (i_read) begin
                    state_d = I_RD;
                end
            end
            I_RD, D_RD, D_WR: begin
                if (pmem_resp && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant    = (state_q == IDLE) && (state_d != IDLE);
    assign grant_wr = grant && (state_d == D_WR);
    assign in_burst = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
    assign beat_vld = in_burst && pmem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_grant_q <= d_wins ? GRANT_D : GRANT_I;
                addr_q       <= d_wins ? {d_address[31:5], 5'd0} : {i_address[31:5], 5'd0};
            end
        end
    end

    line_adapter u_line_adapter (
        .clk          (clk),
        .rst          (rst),
        .clear        (grant),
        .load         (grant_wr),
        .load_line    (d_wdata),
        .beat_vld     (beat_vld),
        .beat_capture (state_q != D_WR),
        .rdata_beat   (pmem_rdata),
        .wdata_beat   (pmem_wdata),
        .line         (line),
        .last_beat    (last_beat)
    );

    // Moore outputs: everything below depends only on registered state
    assign pmem_read    = (state_q == I_RD) || (state_q == D_RD);
    assign pmem_write   = (state_q == D_WR);
    assign pmem_address = addr_q;
    assign i_resp       = (state_q == DONE) && (last_grant_q == GRANT_I);
    assign d_resp       = (state_q == DONE) && (last_grant_q == GRANT_D);
    assign i_rdata      = line;
    assign d_rdata      = line;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a beat-level memory responder plus an
// in-order queue of expected completions.
module tb_cache_arbiter;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [31:0]       i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [31:0]       d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    cache_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           side_d;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   gap = 0;
    int   rsp_k = 0;
    int   wait_c = 0;
    int   last_beat_cyc = -10;
    bit   mdl_last_d = 1'b0;
    bit   prev_resp = 1'b0;
    txn_t rsp_t;
    txn_t mon_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] beat_val(input logic [31:0] a, input int k);
        logic [7:0] b;
        b = 8'(17 * (k + 1));
        if ({a[31:5], 5'd0} == 32'h0000_1220) return {8{b}};
        return {a, 28'hA5A5A5A, 4'(k)};
    endfunction

    function automatic logic [255:0] read_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[64*k +: 64] = beat_val({a[31:5], 5'd0}, k);
        return l;
    endfunction

    // Memory responder: one beat per cycle after 'gap' idle cycles.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (!(pmem_read || pmem_write)) begin
                rsp_k  = 0;
                wait_c = 0;
            end else if (wait_c < gap) begin
                wait_c++;
            end else begin
                if (exp_q.size() > 0) begin
                    rsp_t = exp_q[0];
                    check_eq("pmem_addr", pmem_address, {rsp_t.addr[31:5], 5'd0});
                    check_eq("pmem_dir", {pmem_read, pmem_write}, rsp_t.wr ? 2'b01 : 2'b10);
                    if (rsp_t.wr) check_eq("pmem_wdata", pmem_wdata, rsp_t.line[64*rsp_k +: 64]);
                    pmem_rdata = beat_val(rsp_t.addr, rsp_k);
                end else begin
                    pmem_rdata = beat_val(pmem_address, rsp_k);
                end
                pmem_resp = 1'b1;
                rsp_k++;
                wait_c = 0;
                if (rsp_k == 4) last_beat_cyc = cyc;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every resp.
    initial begin
        forever begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                check_eq("resp_onehot", i_resp ^ d_resp, 1);
                check_eq("resp_pulse", prev_resp, 0);
                check_eq("resp_latency", cyc, last_beat_cyc + 1);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_resp", {i_resp, d_resp}, 0);
                end else begin
                    mon_t = exp_q.pop_front();
                    check_eq("resp_side", d_resp, mon_t.side_d);
                    if (!mon_t.wr) check_eq("rdata", mon_t.side_d ? d_rdata : i_rdata, mon_t.line);
                end
            end
            prev_resp = i_resp || d_resp;
        end
    end

    task automatic push(input bit side_d, input bit wr, input logic [31:0] a, input logic [255:0] l);
        txn_t t;
        t.side_d = side_d;
        t.wr     = wr;
        t.addr   = a;
        t.line   = l;
        exp_q.push_back(t);
        mdl_last_d = side_d;
    endtask

    task automatic wait_resps(input int n);
        int seen = 0;
        int budget = 300;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (i_resp) begin
                i_read = 1'b0;
                seen++;
            end
            if (d_resp) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                seen++;
            end
        end
        check_eq("resp_count", seen, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pmem", {pmem_read, pmem_write, pmem_address, pmem_wdata}, 0);
        check_eq("rst_resp", {i_resp, d_resp}, 0);
        check_eq("rst_lines", {i_rdata, d_rdata}, 0);
        rst = 1'b0;
        mdl_last_d = 1'b0;
    endtask

    task automatic tie_read(input logic [31:0] ia, input logic [31:0] da);
        @(posedge clk);
        #1;
        i_address = ia;
        d_address = da;
        i_read    = 1'b1;
        d_read    = 1'b1;
        if (mdl_last_d) begin
            push(1'b0, 1'b0, ia, read_line(ia));
            push(1'b1, 1'b0, da, read_line(da));
        end else begin
            push(1'b1, 1'b0, da, read_line(da));
            push(1'b0, 1'b0, ia, read_line(ia));
        end
        wait_resps(2);
    endtask

    initial begin
        logic [255:0] wline;
        int           budget;
        i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_address = 0; d_wdata = '0;
        do_reset();

        // I-cache fill alone
        @(posedge clk);
        #1;
        i_address = 32'h0000_1234;
        i_read    = 1'b1;
        push(1'b0, 1'b0, 32'h0000_1234, read_line(32'h0000_1234));
        @(posedge clk);
        #1;
        check_eq("grant_latency_i", pmem_read, 1);
        wait_resps(1);
        @(negedge clk);
        check_eq("i_line_hold", i_rdata,
                 {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});

        // D-cache writeback
        wline = {64'd4, 64'd3, 64'd2, 64'd1};
        @(posedge clk);
        #1;
        d_address = 32'h8000_0040;
        d_wdata   = wline;
        d_write   = 1'b1;
        push(1'b1, 1'b1, 32'h8000_0040, wline);
        @(posedge clk);
        #1;
        check_eq("grant_latency_d", {pmem_read, pmem_write}, 2'b01);
        wait_resps(1);

        // Ties after reset: D first, then alternation
        do_reset();
        tie_read(32'h0000_2000, 32'h0000_3040);
        tie_read(32'h0000_2100, 32'h0000_3140);
        @(posedge clk);
        #1;
        d_address = 32'h0000_5000;
        d_read    = 1'b1;
        push(1'b1, 1'b0, 32'h0000_5000, read_line(32'h0000_5000));
        wait_resps(1);
        tie_read(32'h0000_2200, 32'h0000_3240);

        // Gapped beats
        gap = 3;
        @(posedge clk);
        #1;
        d_address = 32'h4567_89A0;
        d_read    = 1'b1;
        push(1'b1, 1'b0, 32'h4567_89A0, read_line(32'h4567_89A0));
        wait_resps(1);
        gap = 0;

        // Reset in the middle of a burst
        @(posedge clk);
        #1;
        i_address = 32'h1234_5678;
        i_read    = 1'b1;
        push(1'b0, 1'b0, 32'h1234_5678, read_line(32'h1234_5678));
        budget = 50;
        do begin
            @(negedge clk);
            budget--;
        end while (rsp_k < 3 && budget > 0);
        check_eq("mid_burst_reached", rsp_k >= 3, 1);
        rst    = 1'b1;
        i_read = 1'b0;
        @(negedge clk);
        check_eq("abort_pmem", {pmem_read, pmem_write}, 0);
        check_eq("abort_line", i_rdata, 0);
        void'(exp_q.pop_front());
        rst = 1'b0;
        mdl_last_d = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("abort_no_resp", prev_resp, 0);
        @(posedge clk);
        #1;
        i_address = 32'h0000_1234;
        i_read    = 1'b1;
        push(1'b0, 1'b0, 32'h0000_1234, read_line(32'h0000_1234));
        wait_resps(1);

        // Read and write together: writeback only
        wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        d_address = 32'hC000_0080;
        d_wdata   = wline;
        d_read    = 1'b1;
        d_write   = 1'b1;
        push(1'b1, 1'b1, 32'hC000_0080, wline);
        wait_resps(1);

        repeat (3) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
